// File: rtl/monitor_pkg.sv
// Shared definitions for the one-hot ring counter and its downstream monitor.
package monitor_pkg;

    // Default ring width; the upstream ring counter uses the same constant.
    localparam int DEFAULT_NUM_BITS = 4;

    // Lock-tracking states of the ring monitor.
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        ERROR    = 2'd2
    } mon_state_t;

endpackage : monitor_pkg

// File: rtl/onehot_encoder.sv
// Combinational one-hot to binary encoder with a one-hot legality flag.
module onehot_encoder
    import monitor_pkg::*;
#(
    parameter  int NUM_BITS = DEFAULT_NUM_BITS,
    localparam int IDX_W    = $clog2(NUM_BITS)
) (
    input  logic [NUM_BITS-1:0] vec,
    output logic [IDX_W-1:0]    index,
    output logic                is_onehot
);

    // Index of the set bit (meaningful only when is_onehot is 1).
    always_comb begin
        index = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_BITS; i++) begin
            index = vec[i] ? IDX_W'(i) : index;
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    always_comb begin
        is_onehot = (vec != {NUM_BITS{1'b0}}) &&
                    ((vec & (vec - {{(NUM_BITS-1){1'b0}}, 1'b1})) == {NUM_BITS{1'b0}});
    end

endmodule : onehot_encoder

// File: rtl/onehot_ring_monitor.sv
// Monitors a one-hot ring counter: encodes each sample, checks the rotation
// sequence, counts laps and latches errors. Resynchronises on the value 1.
module onehot_ring_monitor
    import monitor_pkg::*;
#(
    parameter  int NUM_BITS = DEFAULT_NUM_BITS,
    parameter  int LAP_W    = 8,
    localparam int IDX_W    = $clog2(NUM_BITS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic [NUM_BITS-1:0] ring_in,
    input  logic                clr_err,
    output logic [IDX_W-1:0]    index,
    output logic                index_valid,
    output logic                locked,
    output logic [LAP_W-1:0]    lap_count,
    output logic                lap_pulse,
    output logic                err_not_onehot,
    output logic                err_sequence,
    output logic                err_sticky
);

    localparam logic [NUM_BITS-1:0] RING_ONE = {{(NUM_BITS-1){1'b0}}, 1'b1};

    mon_state_t          state;
    mon_state_t          state_next;
    logic [NUM_BITS-1:0] prev;
    logic [NUM_BITS-1:0] prev_next;
    logic [NUM_BITS-1:0] expected;
    logic [IDX_W-1:0]    enc_index;
    logic                enc_onehot;
    logic [IDX_W-1:0]    index_next;
    logic                index_valid_next;
    logic [LAP_W-1:0]    lap_count_next;
    logic                lap_pulse_next;
    logic                err_not_onehot_next;
    logic                err_sequence_next;
    logic                err_sticky_next;

    onehot_encoder #(
        .NUM_BITS (NUM_BITS)
    ) u_encoder (
        .vec       (ring_in),
        .index     (enc_index),
        .is_onehot (enc_onehot)
    );

    // Legal successor of the previous sample: rotate left by one position.
    always_comb begin
        expected = {prev[NUM_BITS-2:0], prev[NUM_BITS-1]};
    end

    // Next-state and next-output computation for every registered quantity.
    always_comb begin
        state_next          = state;
        prev_next           = prev;
        index_next          = index;
        index_valid_next    = index_valid;
        lap_count_next      = lap_count;
        lap_pulse_next      = 1'b0;
        err_not_onehot_next = 1'b0;
        err_sequence_next   = 1'b0;

        if (sample_en) begin
            index_valid_next = enc_onehot;
            index_next       = enc_onehot ? enc_index : index;

            case (state)
                UNLOCKED: begin
                    if (enc_onehot) begin
                        prev_next  = ring_in;
                        state_next = LOCKED;
                    end else begin
                        state_next = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (!enc_onehot) begin
                        err_not_onehot_next = 1'b1;
                        state_next          = ERROR;
                    end else if (ring_in == expected) begin
                        prev_next = ring_in;
                        // Wrapping from the MSB back to bit 0 completes a lap.
                        if (prev[NUM_BITS-1]) begin
                            lap_pulse_next = 1'b1;
                            lap_count_next = lap_count + {{(LAP_W-1){1'b0}}, 1'b1};
                        end else begin
                            lap_pulse_next = 1'b0;
                        end
                    end else begin
                        err_sequence_next = 1'b1;
                        state_next        = ERROR;
                    end
                end
                ERROR: begin
                    // Only the ring's reset value re-establishes a known phase.
                    if (ring_in == RING_ONE) begin
                        prev_next  = RING_ONE;
                        state_next = LOCKED;
                    end else begin
                        state_next = ERROR;
                    end
                end
                default: begin
                    prev_next  = {NUM_BITS{1'b0}};
                    state_next = UNLOCKED;
                end
            endcase
        end else begin
            state_next = state;
        end

        // clr_err acts independently of sample_en; a fresh error wins over the clear.
        err_sticky_next = (err_sticky & ~clr_err) | err_not_onehot_next | err_sequence_next;
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= UNLOCKED;
            prev           <= {NUM_BITS{1'b0}};
            index          <= {IDX_W{1'b0}};
            index_valid    <= 1'b0;
            locked         <= 1'b0;
            lap_count      <= {LAP_W{1'b0}};
            lap_pulse      <= 1'b0;
            err_not_onehot <= 1'b0;
            err_sequence   <= 1'b0;
            err_sticky     <= 1'b0;
        end else begin
            state          <= state_next;
            prev           <= prev_next;
            index          <= index_next;
            index_valid    <= index_valid_next;
            locked         <= (state_next == LOCKED);
            lap_count      <= lap_count_next;
            lap_pulse      <= lap_pulse_next;
            err_not_onehot <= err_not_onehot_next;
            err_sequence   <= err_sequence_next;
            err_sticky     <= err_sticky_next;
        end
    end

endmodule : onehot_ring_monitor

// File: doc/onehot_ring_monitor.md
Name: onehot_ring_monitor

Overview:
Sits directly downstream of the one-hot synchronous ring counter (1 -> 2 -> 4 -> 8 -> 1 for 4 bits).
- Samples the ring value and encodes it to a binary index.
- Verifies that every sample is the legal next rotation of the previous one.
- Counts completed laps.
- Flags and latches errors, and resynchronises when the ring returns to its reset value (1).

Parameters:
NUM_BITS, 4, width of the monitored one-hot ring; must match the upstream counter
LAP_W, 8, width of the lap counter
IDX_W, $clog2(NUM_BITS), width of the binary index (derived; not overridden)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
sample_en  input  1  ring_in is valid this cycle; ignored when 0
ring_in  input  NUM_BITS  one-hot value from the ring counter
clr_err  input  1  clears err_sticky
index  output  IDX_W  binary position of the last valid one-hot sample
index_valid  output  1  last sample was one-hot
locked  output  1  FSM in LOCKED
lap_count  output  LAP_W  completed laps since lock/reset
lap_pulse  output  1  one-cycle pulse per completed lap
err_not_onehot  output  1  one-cycle pulse: sample had zero or >1 bits set
err_sequence  output  1  one-cycle pulse: one-hot sample, but not the expected rotation
err_sticky  output  1  latched OR of both error pulses

Behaviour:
- Reset (dominates all inputs):
  - All outputs 0.
  - Internal prev register 0.
  - FSM = UNLOCKED.
- Latency and timing:
  - All outputs are registered.
  - The response to a sample appears the cycle after sample_en=1.
  - Pulses last exactly one cycle.
- When sample_en=0:
  - FSM, prev, index, index_valid, lap_count and err_sticky hold.
  - All pulses = 0.
  - ring_in is don't-care.
- One-hot test: exactly one bit set. On a non-one-hot sample:
  - index_valid=0 and index holds.
  - err_not_onehot pulses only when the FSM is LOCKED.
- Expected next value = rotate-left of prev: prev[NUM_BITS-1]=1 gives 1, otherwise prev<<1.
- FSM, evaluated on each sample:
  - UNLOCKED: a one-hot sample (any position) stores prev and moves to LOCKED. A non-one-hot sample stays in UNLOCKED with no error.
  - LOCKED, sample == expected: update prev. If prev was the MSB value, lap_pulse=1 and lap_count+1, wrapping 2^LAP_W-1 -> 0.
  - LOCKED, not one-hot: err_not_onehot, move to ERROR.
  - LOCKED, one-hot but != expected (includes a repeated value): err_sequence, move to ERROR.
  - ERROR: ignore samples except a sample exactly equal to 1, which moves to LOCKED with prev=1. No further error pulses while in ERROR. lap_count holds throughout ERROR.
- Resync after ERROR: lap_count is NOT cleared; only reset clears it.
- Entering LOCKED from UNLOCKED: lap_count is not incremented, even if the first sample is 1.
- err_sticky:
  - Set by either error pulse condition.
  - Cleared by clr_err.
  - A new error in the same cycle as clr_err wins (err_sticky=1).
- Reset mid-operation (any state): next cycle matches the reset values above; the lock process restarts.
- Width: index = position of the set bit, LSB = 0.

Decomposition:
Shared package monitor_pkg:
- typedef enum logic [1:0] {UNLOCKED, LOCKED, ERROR} mon_state_t
- NUM_BITS default constant, shared with the ring counter

One sub-module: onehot_encoder (combinational).
- Inputs: NUM_BITS vector.
- Outputs: IDX_W index and is_onehot flag.
- The FSM, lap counter and error latch stay in onehot_ring_monitor.

Test Plan:
1. Reset, then samples 1,2,4,8,1 on consecutive cycles:
   - locked=1 after the first sample.
   - index 0,1,2,3,0.
   - lap_pulse high for one cycle only, after the 8->1 sample.
   - lap_count=1; no errors.
2. Lock mid-ring: first sample 4, then 8, 1:
   - locked=1, index 2.
   - lap_pulse on the 1; lap_count=1.
3. Locked at 2, sample 0110:
   - err_not_onehot=1 for one cycle, index_valid=0, locked=0, err_sticky=1.
   - Then sample 4: stays ERROR, no pulse.
   - Then sample 1: locked=1, index 0.
   - Then clr_err: err_sticky=0.
4. Locked at 2, sample 8: err_sequence one-cycle pulse, ERROR. Repeat from locked at 2 with sample 2: same response.
5. Sample 1, then sample_en=0 for 5 cycles with ring_in=0111, then sample 2: no error, index 1, outputs held during the gap.
6. Boundaries:
   - LAP_W=2, 4 full laps: lap_count 1,2,3,0.
   - Assert reset while locked with lap_count=2: all outputs 0, UNLOCKED next cycle.
   - clr_err together with an error: err_sticky stays 1.
